// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one outstanding req/gnt/rvalid fetch, results buffered in a small FIFO.
// Define IFETCH_BYPASS_EN to forward a response straight to the consumer when the FIFO is empty.
module ifetch_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_valid_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_ready_o,
    input  logic            redirect_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            imem_err_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic [1:0]      instr_err_o,
    input  logic            instr_ready_i
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e          state_q;
    logic [XLEN-1:0] addr_q;
    logic            req_q;
    logic            drop_q;
    logic [31:0]     buf_instr_q [BUF_DEPTH];
    logic [XLEN-1:0] buf_pc_q    [BUF_DEPTH];
    logic [1:0]      buf_err_q   [BUF_DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    logic            accept;
    logic            misaligned;
    logic            resp;
    logic            bypass;
    logic            push;
    logic            pop;
    logic [31:0]     push_instr;
    logic [XLEN-1:0] push_pc;
    logic [1:0]      push_err;

    always_comb begin
        // A free slot is reserved for the fetch before it is issued, so a push never overflows.
        pc_ready_o = (state_q == StIdle) && (count_q < CW'(BUF_DEPTH));
        accept     = pc_valid_i && pc_ready_o;
        misaligned = (pc_i[1:0] != 2'b00);
        resp       = (state_q == StWait) && imem_rvalid_i && !drop_q && !redirect_i;
`ifdef IFETCH_BYPASS_EN
        bypass     = resp && (count_q == '0) && instr_ready_i;
`else
        bypass     = 1'b0;
`endif
        push       = (accept && misaligned) || (resp && !bypass);
        pop        = (count_q != '0) && instr_ready_i && !redirect_i;
        if (accept && misaligned) begin
            push_instr = NOP_INSTR;
            push_pc    = pc_i;
            push_err   = 2'b01;
        end else begin
            push_instr = imem_err_i ? NOP_INSTR : imem_rdata_i;
            push_pc    = addr_q;
            push_err   = {imem_err_i, 1'b0};
        end
    end

    always_comb begin
        imem_req_o    = req_q;
        imem_addr_o   = addr_q;
        instr_valid_o = (count_q != '0);
        instr_o       = buf_instr_q[rd_ptr_q];
        instr_pc_o    = buf_pc_q[rd_ptr_q];
        instr_err_o   = buf_err_q[rd_ptr_q];
`ifdef IFETCH_BYPASS_EN
        if (bypass) begin
            instr_valid_o = 1'b1;
            instr_o       = push_instr;
            instr_pc_o    = push_pc;
            instr_err_o   = push_err;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            req_q    <= 1'b0;
            drop_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_instr_q[i] <= '0;
                buf_pc_q[i]    <= '0;
                buf_err_q[i]   <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept && !misaligned) begin
                        addr_q  <= pc_i;
                        req_q   <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    // The bus request cannot be retracted; a flush only marks its response stale.
                    if (redirect_i) drop_q <= 1'b1;
                    if (imem_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (imem_rvalid_i) begin
                        drop_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (redirect_i) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (redirect_i) begin
                // A misaligned target accepted with the flush survives it as the only entry.
                rd_ptr_q <= '0;
                wr_ptr_q <= push ? PW'(1) : '0;
                count_q  <= push ? CW'(1) : '0;
                if (push) begin
                    buf_instr_q[0] <= push_instr;
                    buf_pc_q[0]    <= push_pc;
                    buf_err_q[0]   <= push_err;
                end
            end else begin
                if (push) begin
                    buf_instr_q[wr_ptr_q] <= push_instr;
                    buf_pc_q[wr_ptr_q]    <= push_pc;
                    buf_err_q[wr_ptr_q]   <= push_err;
                    wr_ptr_q              <= wr_ptr_q + PW'(1);
                end
                if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
                if (push && !pop) begin
                    count_q <= count_q + CW'(1);
                end else if (!push && pop) begin
                    count_q <= count_q - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: directed scenarios, then randomized traffic.
module tb_ifetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  err;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_valid_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        pc_ready_o;
    logic        redirect_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        imem_err_i = 1'b0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [1:0]  instr_err_o;
    logic        instr_ready_i = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state: expected FIFO contents and the single outstanding fetch.
    entry_t      exp_q[$];
    bit          outstanding = 0;
    bit          granted = 0;
    bit          dropped = 0;
    logic [31:0] out_pc = '0;
    entry_t      mon_e;
    entry_t      new_e;

    ifetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_valid_i   (pc_valid_i),
        .pc_i         (pc_i),
        .pc_ready_o   (pc_ready_o),
        .redirect_i   (redirect_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .imem_err_i   (imem_err_i),
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .instr_err_o  (instr_err_o),
        .instr_ready_i(instr_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: compares DUT against the model state as it stood at the start of the cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("instr_valid", instr_valid_o, exp_q.size() != 0);
            check("pc_ready", pc_ready_o, !outstanding && exp_q.size() < DEPTH);
            check("imem_req", imem_req_o, outstanding && !granted);
            if (imem_req_o && outstanding) check("imem_addr", imem_addr_o, out_pc);
            if (instr_valid_o && instr_ready_i && !redirect_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop: got instr %h pc %h, required no entry", instr_o, instr_pc_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("instr", instr_o, mon_e.instr);
                    check("instr_pc", instr_pc_o, mon_e.pc);
                    check("instr_err", instr_err_o, mon_e.err);
                end
            end
        end
    end

    // Model: applies this cycle's events (flush, response, accept) after the monitor has looked.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            exp_q.delete();
            outstanding = 0;
            granted     = 0;
            dropped     = 0;
        end else begin
            if (redirect_i) begin
                exp_q.delete();
                if (outstanding) dropped = 1;
            end
            if (outstanding && granted && imem_rvalid_i) begin
                if (!dropped) begin
                    new_e = {imem_err_i ? NOP : imem_rdata_i, out_pc, {imem_err_i, 1'b0}};
                    exp_q.push_back(new_e);
                end
                outstanding = 0;
                granted     = 0;
                dropped     = 0;
            end else if (outstanding && !granted && imem_gnt_i) begin
                granted = 1;
            end
            if (pc_valid_i && pc_ready_o) begin
                if (pc_i[1:0] != 2'b00) begin
                    new_e = {NOP, pc_i, 2'b01};
                    exp_q.push_back(new_e);
                end else begin
                    outstanding = 1;
                    granted     = 0;
                    dropped     = 0;
                    out_pc      = pc_i;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, instr_valid_o, 1'b0);
        check({tag, "_instr"}, instr_o, 32'h0);
        check({tag, "_pc"}, instr_pc_o, 32'h0);
        check({tag, "_err"}, instr_err_o, 2'b00);
        check({tag, "_req"}, imem_req_o, 1'b0);
        check({tag, "_addr"}, imem_addr_o, 32'h0);
        check({tag, "_pc_ready"}, pc_ready_o, 1'b1);
    endtask

    task automatic issue(input logic [31:0] addr);
        int n = 0;
        while (!pc_ready_o && n < 20) begin
            step();
            n++;
        end
        if (!pc_ready_o) begin
            checks++;
            errors++;
            $display("FAIL issue_wait: pc_ready_o stays 0, required 1");
        end
        pc_valid_i = 1'b1;
        pc_i       = addr;
        step();
        pc_valid_i = 1'b0;
        if (addr[1:0] != 2'b00) check("misaligned_no_req", imem_req_o, 1'b0);
    endtask

    task automatic grant(input logic [31:0] addr, input int delay);
        for (int i = 0; i < delay; i++) begin
            check("stall_req", imem_req_o, 1'b1);
            check("stall_addr", imem_addr_o, addr);
            step();
        end
        check("gnt_req", imem_req_o, 1'b1);
        check("gnt_addr", imem_addr_o, addr);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic err);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data;
        imem_err_i    = err;
        step();
        imem_rvalid_i = 1'b0;
        imem_err_i    = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, input int delay, input logic [31:0] data,
                         input logic err);
        issue(addr);
        if (addr[1:0] == 2'b00) begin
            grant(addr, delay);
            respond(data, err);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_idle_outputs("reset");

        // Basic fetch: accept at N, request at N+1, rvalid at N+2, instruction visible at N+3.
        issue(32'h100);
        grant(32'h100, 0);
        check("basic_not_early", instr_valid_o, 1'b0);
        respond(32'h00A00093, 1'b0);
        check("basic_valid", instr_valid_o, 1'b1);
        check("basic_instr", instr_o, 32'h00A00093);
        check("basic_pc", instr_pc_o, 32'h100);
        check("basic_err", instr_err_o, 2'b00);
        instr_ready_i = 1'b1;
        repeat (2) step();

        // Misaligned target and bus error.
        fetch(32'h102, 0, 32'h0, 1'b0);
        fetch(32'h104, 0, 32'hDEADBEEF, 1'b1);
        // Grant held off for four cycles.
        fetch(32'h20, 4, 32'h00000513, 1'b0);
        repeat (2) step();

        // Backpressure: two entries fill the buffer, then drain in order and wrap.
        instr_ready_i = 1'b0;
        fetch(32'h0, 0, 32'h11111111, 1'b0);
        fetch(32'h4, 1, 32'h22222222, 1'b0);
        check("full_pc_ready", pc_ready_o, 1'b0);
        instr_ready_i = 1'b1;
        repeat (3) step();
        fetch(32'h8, 0, 32'h33333333, 1'b0);
        repeat (2) step();

        // Redirect while waiting, then redirect in idle carrying a new target.
        instr_ready_i = 1'b0;
        fetch(32'h2C, 0, 32'h44444444, 1'b0);
        issue(32'h30);
        grant(32'h30, 0);
        redirect_i = 1'b1;
        step();
        redirect_i = 1'b0;
        respond(32'h55555555, 1'b0);
        fetch(32'h34, 0, 32'h66666666, 1'b0);
        redirect_i = 1'b1;
        pc_valid_i = 1'b1;
        pc_i       = 32'h40;
        step();
        redirect_i = 1'b0;
        pc_valid_i = 1'b0;
        check("flush_empty", instr_valid_o, 1'b0);
        grant(32'h40, 0);
        respond(32'h00100113, 1'b0);
        instr_ready_i = 1'b1;
        repeat (2) step();

        // Reset while waiting; the late response must be ignored.
        issue(32'h50);
        grant(32'h50, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle_outputs("midreset");
        respond(32'h77777777, 1'b0);
        check("late_rvalid_valid", instr_valid_o, 1'b0);
        check("late_rvalid_ready", pc_ready_o, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            pc_valid_i    = 1'($urandom_range(0, 1));
            pc_i          = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 7) == 0) pc_i[1:0] = 2'($urandom_range(1, 3));
            redirect_i    = ($urandom_range(0, 15) == 0);
            instr_ready_i = ($urandom_range(0, 3) != 0);
            imem_gnt_i    = 1'($urandom_range(0, 1));
            imem_rvalid_i = (outstanding && granted) ? 1'($urandom_range(0, 1))
                                                     : ($urandom_range(0, 15) == 0);
            imem_rdata_i  = $urandom;
            imem_err_i    = ($urandom_range(0, 7) == 0);
            step();
        end

        pc_valid_i    = 1'b0;
        redirect_i    = 1'b0;
        instr_ready_i = 1'b1;
        imem_err_i    = 1'b0;
        for (int n = 0; n < 200 && (exp_q.size() != 0 || outstanding); n++) begin
            imem_gnt_i    = 1'b1;
            imem_rvalid_i = outstanding && granted;
            step();
        end
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        checks++;
        if (exp_q.size() != 0 || outstanding) begin
            errors++;
            $display("FAIL drain: %0d entries still expected, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
